cv32e40x_hazard_scoreboard: RTL
===============================

Name: cv32e40x_hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the ID stage. It generalises the fixed EX/WB bypass to N read ports and S forwarding stages, and adds a register scoreboard for long-latency producers (divider, offloaded coprocessor ops) that write back out of order. It drives the operand forward-mux selects, the jump-register forward select, the stall and write-enable deassert to the decoder, and optional stall performance counters.

Parameters:
NUM_READ_PORTS, 2, register file read ports checked in ID
NUM_FW_STAGES, 2, forwarding stages after ID; index 0 = EX (youngest), NUM_FW_STAGES-1 = WB (oldest)
MAX_OUTSTANDING, 4, max in-flight long-latency ops (>=1)
REG_ADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
is_decoding_i  in  1  controller FSM is in decode state
id_valid_i  in  1  valid instruction in ID
id_ready_i  in  1  ID hands the instruction to EX this cycle
rf_re_i  in  NUM_READ_PORTS  read enables from the decoder
rf_raddr_i  in  NUM_READ_PORTS*REG_ADDR_W  read addresses, port 0 in the LSBs
rf_we_id_i  in  1  ID instruction writes rd
rf_waddr_id_i  in  REG_ADDR_W  ID destination register
id_long_lat_i  in  1  ID instruction is a long-latency producer
jalr_i  in  1  ID instruction is JALR (rs1 is port 0)
stg_we_i  in  NUM_FW_STAGES  per-stage register write enable
stg_waddr_i  in  NUM_FW_STAGES*REG_ADDR_W  per-stage write address
stg_rdy_i  in  NUM_FW_STAGES  per-stage result is forwardable this cycle
ll_done_i  in  1  a long-latency op writes back this cycle
ll_waddr_i  in  REG_ADDR_W  register written by the completing op
op_fw_sel_o  out  NUM_READ_PORTS*SW  per port: 0 = regfile, s+1 = stage s; SW = $clog2(NUM_FW_STAGES+1)
jalr_fw_sel_o  out  1  1 = take the jump target from the oldest stage
stall_o  out  1  ID must hold
deassert_we_o  out  1  deassert write enables in the decoder
sb_full_o  out  1  outstanding count equals MAX_OUTSTANDING
stall_data_cnt_o  out  32  data-hazard stall cycles (feature only)
stall_sb_cnt_o  out  32  scoreboard stall cycles (feature only)

Behaviour:
- Match rule: port p matches stage s when rf_re_i[p], the read address is nonzero, stg_we_i[s] and the addresses are equal.
- Forwarding: the youngest matching stage wins. Select = s+1 if stg_rdy_i[s], otherwise data_haz[p] = 1. With no stage match the select is 0.
- Scoreboard: busy vector of 2^REG_ADDR_W bits (x0 is never set) plus an outstanding counter of width $clog2(MAX_OUTSTANDING+1).
- Set: the rd busy bit is set on id_valid_i & id_ready_i & id_long_lat_i & rf_we_id_i, with rd nonzero.
- Clear: ll_done_i clears the ll_waddr_i busy bit.
- Issue and completion of the same register in the same cycle: the bit stays 1 and the counter is unchanged.
- Counter: +1 on issue, -1 on completion, unchanged when both happen. A completion at count 0 is an error; the counter saturates at 0.
- sb_haz:
  - any enabled read port hits a busy register (RAW);
  - rf_we_id_i hits a busy rd (WAW);
  - id_long_lat_i while sb_full_o.
- JALR: jalr_fw_sel_o = 1 only when the oldest stage matches port 0, stg_rdy_i is high there, and no younger stage matches. Any other port-0 stage match sets jr_haz.
- stall_o = id_valid_i & (|data_haz | sb_haz | jr_haz).
- deassert_we_o = !is_decoding_i | stall_o.
- All outputs are combinational from the inputs and the scoreboard state.
- Reset: busy = 0, counter = 0, perf counters = 0. All outputs are 0 during reset except deassert_we_o, which still follows !is_decoding_i.
- Flush: issued long-latency ops are non-speculative, so the scoreboard is not flushed. A reset mid-operation discards all entries, and a later ll_done_i with count 0 is ignored.

Optional Feature:
- Macro: CV32E40X_HAZARD_PERF_EN.
- When defined:
  - stall_data_cnt_o counts cycles with stall_o & (|data_haz | jr_haz);
  - stall_sb_cnt_o counts cycles with stall_o & sb_haz & no data or jump hazard;
  - both counters saturate at 32'hFFFF_FFFF.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Stage0 we=1, waddr=5, rdy=1; port1 reads x5 -> op_fw_sel port1 = 1, stall_o = 0.
- Stage0 rdy=0 and stage1 rdy=1, both writing x7; port0 reads x7 -> stall_o = 1, deassert_we_o = 1. Raise stage0 rdy -> select = 1, stall_o = 0.
- Issue a long op to x9, then an ID read of x9 -> stall_o = 1 until ll_done_i with ll_waddr=9. The next cycle stall_o = 0 and the counter returns to 0.
- MAX_OUTSTANDING=4: issue 4 ops to x1..x4 -> sb_full_o = 1 and a 5th long op stalls. ll_done_i for x2 and a new issue to x6 in the same cycle -> count stays 4.
- jalr_i, port0 = x3, only the oldest stage writes x3 with rdy=1 -> jalr_fw_sel_o = 1, no stall. If the EX stage also writes x3 -> stall_o = 1, jalr_fw_sel_o = 0.
- Perf macro on: 10 data-hazard stall cycles, then rst held for 1 cycle -> stall_data_cnt_o reads 10, then 0 after reset. Macro off -> the counter ports read 0.

Source files
------------

// File: rtl/cv32e40x_hazard_scoreboard.sv
// ID-stage hazard and forwarding unit with a long-latency register scoreboard.
// Selects the forwarding source for each read port and for the JALR target. Raises
// stall_o on data, jump-register and scoreboard hazards.
// Optional stall performance counters are built only when CV32E40X_HAZARD_PERF_EN is defined.
module cv32e40x_hazard_scoreboard #(
  parameter int unsigned NUM_READ_PORTS  = 2,
  parameter int unsigned NUM_FW_STAGES   = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned REG_ADDR_W      = 5,
  localparam int unsigned SW    = $clog2(NUM_FW_STAGES + 1),
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned NREGS = 1 << REG_ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 is_decoding_i,
  input  logic                                 id_valid_i,
  input  logic                                 id_ready_i,
  input  logic [NUM_READ_PORTS-1:0]            rf_re_i,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rf_raddr_i,
  input  logic                                 rf_we_id_i,
  input  logic [REG_ADDR_W-1:0]                rf_waddr_id_i,
  input  logic                                 id_long_lat_i,
  input  logic                                 jalr_i,
  input  logic [NUM_FW_STAGES-1:0]             stg_we_i,
  input  logic [NUM_FW_STAGES*REG_ADDR_W-1:0]  stg_waddr_i,
  input  logic [NUM_FW_STAGES-1:0]             stg_rdy_i,
  input  logic                                 ll_done_i,
  input  logic [REG_ADDR_W-1:0]                ll_waddr_i,
  output logic [NUM_READ_PORTS*SW-1:0]         op_fw_sel_o,
  output logic                                 jalr_fw_sel_o,
  output logic                                 stall_o,
  output logic                                 deassert_we_o,
  output logic                                 sb_full_o,
  output logic [31:0]                          stall_data_cnt_o,
  output logic [31:0]                          stall_sb_cnt_o
);

  localparam int unsigned OLDEST = NUM_FW_STAGES - 1;

  logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0] raddr;
  logic [NUM_FW_STAGES-1:0][REG_ADDR_W-1:0]  waddr;
  logic [NUM_READ_PORTS-1:0][NUM_FW_STAGES-1:0] match;
  logic [NUM_READ_PORTS-1:0][SW-1:0] fw_sel;
  logic [NUM_READ_PORTS-1:0]         data_haz;

  logic jalr_fw, jr_haz, port0_younger;
  logic sb_raw, sb_waw, sb_cap, sb_haz, sb_full, stall_int;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue, complete;

  assign raddr = rf_raddr_i;
  assign waddr = stg_waddr_i;

  // Port/stage address match matrix; x0 never matches.
  always_comb begin
    match = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      for (int s = 0; s < int'(NUM_FW_STAGES); s++) begin
        match[p][s] = rf_re_i[p] && (raddr[p] != '0) && stg_we_i[s] && (raddr[p] == waddr[s]);
      end
    end
  end

  // Forward-mux select per port; walk oldest to youngest so the youngest match wins.
  always_comb begin
    fw_sel   = '0;
    data_haz = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      for (int s = int'(NUM_FW_STAGES) - 1; s >= 0; s--) begin
        if (match[p][s]) begin
          if (stg_rdy_i[s]) begin
            fw_sel[p]   = SW'(s + 1);
            data_haz[p] = 1'b0;
          end else begin
            fw_sel[p]   = '0;
            data_haz[p] = 1'b1;
          end
        end
      end
    end
  end

  // JALR target may only come from the oldest stage; any other port-0 match stalls.
  always_comb begin
    port0_younger = 1'b0;
    for (int s = 0; s < int'(NUM_FW_STAGES) - 1; s++) begin
      port0_younger = port0_younger | match[0][s];
    end
    jalr_fw = jalr_i && match[0][OLDEST] && stg_rdy_i[OLDEST] && !port0_younger;
    jr_haz  = jalr_i && (|match[0]) && !jalr_fw;
  end

  // Scoreboard hazards: RAW on any read port, WAW on rd, and no free slot for a new long op.
  always_comb begin
    sb_raw = 1'b0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      if (rf_re_i[p] && busy_q[raddr[p]]) sb_raw = 1'b1;
    end
    sb_full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    sb_waw  = rf_we_id_i && busy_q[rf_waddr_id_i];
    sb_cap  = id_long_lat_i && sb_full;
    sb_haz  = sb_raw || sb_waw || sb_cap;
  end

  assign stall_int = id_valid_i && ((|data_haz) || sb_haz || jr_haz);

  // Outputs are forced quiet during reset; deassert_we_o still tracks the decode state.
  assign op_fw_sel_o   = rst ? '0 : fw_sel;
  assign jalr_fw_sel_o = !rst && jalr_fw;
  assign stall_o       = !rst && stall_int;
  assign sb_full_o     = !rst && sb_full;
  assign deassert_we_o = !is_decoding_i || stall_o;

  // A completion with nothing outstanding is dropped (e.g. a writeback from before a reset).
  assign issue    = id_valid_i && id_ready_i && id_long_lat_i && rf_we_id_i &&
                    (rf_waddr_id_i != '0);
  assign complete = ll_done_i && (cnt_q != '0);

  // Scoreboard next state; the set is applied after the clear so same-register reuse stays busy.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (complete) busy_d[ll_waddr_i] = 1'b0;
    if (issue) busy_d[rf_waddr_id_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (issue && !complete && !sb_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue && complete) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef CV32E40X_HAZARD_PERF_EN
  logic [31:0] data_cnt_q, sb_cnt_q;
  logic        data_stall, sb_stall;

  assign data_stall = stall_int && ((|data_haz) || jr_haz);
  assign sb_stall   = stall_int && sb_haz && !((|data_haz) || jr_haz);

  // Saturating stall-cycle counters, split by hazard cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_cnt_q <= '0;
      sb_cnt_q   <= '0;
    end else begin
      if (data_stall && (data_cnt_q != '1)) data_cnt_q <= data_cnt_q + 32'd1;
      if (sb_stall && (sb_cnt_q != '1)) sb_cnt_q <= sb_cnt_q + 32'd1;
    end
  end

  assign stall_data_cnt_o = rst ? '0 : data_cnt_q;
  assign stall_sb_cnt_o   = rst ? '0 : sb_cnt_q;
`else
  assign stall_data_cnt_o = '0;
  assign stall_sb_cnt_o   = '0;
`endif

endmodule
